// File: rtl/register_file_mp.sv
// Multi-port integer register file with optional write-to-read bypass and a
// per-register pending-write scoreboard. Register 0 is hardwired to zero.
module register_file_mp #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NR     = 2,
  parameter int NW     = 1,
  parameter int BYPASS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NR*ADDR_W-1:0] ra,
  output logic [NR*DATA_W-1:0] rd,
  output logic [NR-1:0]        rpend,
  input  logic [NW-1:0]        we,
  input  logic [NW*ADDR_W-1:0] wa,
  input  logic [NW*DATA_W-1:0] wd,
  input  logic                 sb_set,
  input  logic [ADDR_W-1:0]    sb_addr
);

  // Register 0 has no storage; out-of-range addresses never match a register.
  logic [DATA_W-1:0] rf [1:DEPTH-1];
  logic [DEPTH-1:1]  pend;

  // Later assignments win: port 1 beats port 0, scoreboard set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 1; r < DEPTH; r++) begin
        rf[r]   <= '0;
        pend[r] <= 1'b0;
      end
    end else begin
      for (int unsigned r = 1; r < DEPTH; r++) begin
        for (int unsigned j = 0; j < NW; j++) begin
          if (we[j] && wa[j*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
            rf[r]   <= wd[j*DATA_W +: DATA_W];
            pend[r] <= 1'b0;
          end
        end
        if (sb_set && sb_addr == ADDR_W'(r)) pend[r] <= 1'b1;
      end
    end
  end

  always_comb begin
    rd    = '0;
    rpend = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      for (int unsigned r = 1; r < DEPTH; r++) begin
        if (ra[i*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
          rd[i*DATA_W +: DATA_W] = rf[r];
          rpend[i]               = pend[r];
          if (BYPASS != 0) begin
            for (int unsigned j = 0; j < NW; j++) begin
              if (we[j] && wa[j*ADDR_W +: ADDR_W] == ADDR_W'(r)) begin
                rd[i*DATA_W +: DATA_W] = wd[j*DATA_W +: DATA_W];
                rpend[i]               = 1'b0;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp: three instances cover dual-write bypass,
// no-bypass, and a reduced-depth four-read-port configuration.
module tb_register_file_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // Instance A: defaults with two write ports (BYPASS = 1)
  logic [9:0]  ra_a = '0;
  logic [63:0] rd_a;
  logic [1:0]  rpend_a;
  logic [1:0]  we_a = '0;
  logic [9:0]  wa_a = '0;
  logic [63:0] wd_a = '0;
  logic        sb_set_a = 1'b0;
  logic [4:0]  sb_addr_a = '0;

  // Instance B: single write port, no bypass
  logic [9:0]  ra_b = '0;
  logic [63:0] rd_b;
  logic [1:0]  rpend_b;
  logic [0:0]  we_b = '0;
  logic [4:0]  wa_b = '0;
  logic [31:0] wd_b = '0;
  logic        sb_set_b = 1'b0;
  logic [4:0]  sb_addr_b = '0;

  // Instance C: DEPTH 16 with four read ports
  logic [19:0]  ra_c = '0;
  logic [127:0] rd_c;
  logic [3:0]   rpend_c;
  logic [0:0]   we_c = '0;
  logic [4:0]   wa_c = '0;
  logic [31:0]  wd_c = '0;
  logic         sb_set_c = 1'b0;
  logic [4:0]   sb_addr_c = '0;

  register_file_mp #(.NW(2)) ua (
    .clk(clk), .rst_n(rst_n), .ra(ra_a), .rd(rd_a), .rpend(rpend_a),
    .we(we_a), .wa(wa_a), .wd(wd_a), .sb_set(sb_set_a), .sb_addr(sb_addr_a)
  );

  register_file_mp #(.NW(1), .BYPASS(0)) ub (
    .clk(clk), .rst_n(rst_n), .ra(ra_b), .rd(rd_b), .rpend(rpend_b),
    .we(we_b), .wa(wa_b), .wd(wd_b), .sb_set(sb_set_b), .sb_addr(sb_addr_b)
  );

  register_file_mp #(.DEPTH(16), .NR(4), .NW(1)) uc (
    .clk(clk), .rst_n(rst_n), .ra(ra_c), .rd(rd_c), .rpend(rpend_c),
    .we(we_c), .wa(wa_c), .wd(wd_c), .sb_set(sb_set_c), .sb_addr(sb_addr_c)
  );

  task automatic test_reset();
    ra_a = {5'd31, 5'd5};
    ra_b = {5'd31, 5'd5};
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (rd_a !== 64'h0 || rpend_a !== 2'b00) begin
      errors++;
      $display("FAIL reset_hold: rd=%h rpend=%b, expected 0/00", rd_a, rpend_a);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (rd_a !== 64'h0 || rpend_a !== 2'b00 || rd_b !== 64'h0 || rpend_b !== 2'b00) begin
      errors++;
      $display("FAIL reset_release: rd_a=%h rpend_a=%b rd_b=%h rpend_b=%b, expected zeros",
               rd_a, rpend_a, rd_b, rpend_b);
    end
    // write x5, confirm, then reset asynchronously mid-cycle
    we_a = 2'b01; wa_a = {5'd0, 5'd5}; wd_a = {32'h0, 32'h12345678};
    @(negedge clk);
    we_a = 2'b00;
    #1;
    checks++;
    if (rd_a[31:0] !== 32'h12345678) begin
      errors++;
      $display("FAIL reset_prewrite: x5=%h, expected 12345678", rd_a[31:0]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rd_a[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL reset_async: x5=%h, expected 00000000", rd_a[31:0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_x0_guard();
    @(negedge clk);
    we_a = 2'b01; wa_a = '0; wd_a = {32'h0, 32'hDEADBEEF};
    sb_set_a = 1'b1; sb_addr_a = 5'd0; ra_a = '0;
    #1;
    checks++;
    if (rd_a[31:0] !== 32'h0 || rpend_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL x0_same_cycle: rd=%h rpend=%b, expected 0/0", rd_a[31:0], rpend_a[0]);
    end
    @(negedge clk);
    we_a = '0; sb_set_a = 1'b0;
    #1;
    checks++;
    if (rd_a[31:0] !== 32'h0 || rpend_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL x0_next_cycle: rd=%h rpend=%b, expected 0/0", rd_a[31:0], rpend_a[0]);
    end
  endtask

  task automatic test_bypass();
    @(negedge clk);
    we_a = 2'b01; wa_a = {5'd0, 5'd7}; wd_a = {32'h0, 32'hCAFEF00D}; ra_a = {5'd0, 5'd7};
    we_b = 1'b1;  wa_b = 5'd7;         wd_b = 32'hCAFEF00D;          ra_b = {5'd0, 5'd7};
    #1;
    checks++;
    if (rd_a[31:0] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL bypass_on_same: rd=%h, expected cafef00d", rd_a[31:0]);
    end
    checks++;
    if (rd_b[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL bypass_off_same: rd=%h, expected 00000000", rd_b[31:0]);
    end
    @(negedge clk);
    we_a = '0; we_b = '0;
    #1;
    checks++;
    if (rd_a[31:0] !== 32'hCAFEF00D || rd_b[31:0] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL bypass_next: rd_a=%h rd_b=%h, expected cafef00d", rd_a[31:0], rd_b[31:0]);
    end
  endtask

  task automatic test_collision();
    @(negedge clk);
    we_a = 2'b11; wa_a = {5'd3, 5'd3}; wd_a = {32'h22222222, 32'h11111111}; ra_a = {5'd3, 5'd3};
    #1;
    checks++;
    if (rd_a !== {2{32'h22222222}}) begin
      errors++;
      $display("FAIL collision_bypass: rd=%h, expected 2222222222222222", rd_a);
    end
    @(negedge clk);
    we_a = '0;
    #1;
    checks++;
    if (rd_a !== {2{32'h22222222}}) begin
      errors++;
      $display("FAIL collision_stored: rd=%h, expected 2222222222222222", rd_a);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    sb_set_a = 1'b1; sb_addr_a = 5'd9; ra_a = {5'd0, 5'd9};
    sb_set_b = 1'b1; sb_addr_b = 5'd9; ra_b = {5'd0, 5'd9};
    #1;
    checks++;
    if (rpend_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL sb_set_same_cycle: rpend=%b, expected 0", rpend_a[0]);
    end
    @(negedge clk);
    sb_set_a = 1'b0; sb_set_b = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (rpend_a[0] !== 1'b1 || rpend_b[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_pending: rpend_a=%b rpend_b=%b, expected 1/1", rpend_a[0], rpend_b[0]);
    end
    @(negedge clk);
    we_a = 2'b01; wa_a = {5'd0, 5'd9}; wd_a = {32'h0, 32'hA5A5A5A5};
    we_b = 1'b1;  wa_b = 5'd9;         wd_b = 32'hA5A5A5A5;
    #1;
    checks++;
    if (rpend_a[0] !== 1'b0 || rd_a[31:0] !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL sb_resolve_bypass: rpend=%b rd=%h, expected 0/a5a5a5a5", rpend_a[0], rd_a[31:0]);
    end
    checks++;
    if (rpend_b[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_resolve_nobypass: rpend=%b, expected 1", rpend_b[0]);
    end
    @(negedge clk);
    we_a = '0; we_b = '0;
    #1;
    checks++;
    if (rpend_a[0] !== 1'b0 || rpend_b[0] !== 1'b0) begin
      errors++;
      $display("FAIL sb_cleared: rpend_a=%b rpend_b=%b, expected 0/0", rpend_a[0], rpend_b[0]);
    end
    // set and clear the same register on one edge
    @(negedge clk);
    we_a = 2'b01; wa_a = {5'd0, 5'd9}; wd_a = {32'h0, 32'h00000009};
    sb_set_a = 1'b1; sb_addr_a = 5'd9;
    @(negedge clk);
    we_a = '0; sb_set_a = 1'b0;
    #1;
    checks++;
    if (rpend_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL sb_set_wins: rpend=%b, expected 1", rpend_a[0]);
    end
    // set x10 while clearing x9 on one edge
    @(negedge clk);
    we_a = 2'b01; wa_a = {5'd0, 5'd9}; wd_a = {32'h0, 32'h00000099};
    sb_set_a = 1'b1; sb_addr_a = 5'd10; ra_a = {5'd10, 5'd9};
    @(negedge clk);
    we_a = '0; sb_set_a = 1'b0;
    #1;
    checks++;
    if (rpend_a !== 2'b10) begin
      errors++;
      $display("FAIL sb_set_clear_split: rpend=%b, expected 10", rpend_a);
    end
  endtask

  task automatic test_corner();
    @(negedge clk);
    we_c = 1'b1; wa_c = 5'd20; wd_c = 32'hFFFFFFFF;
    sb_set_c = 1'b1; sb_addr_c = 5'd20; ra_c = {4{5'd20}};
    #1;
    checks++;
    if (rd_c !== 128'h0 || rpend_c !== 4'b0000) begin
      errors++;
      $display("FAIL oor_same_cycle: rd=%h rpend=%b, expected 0/0000", rd_c, rpend_c);
    end
    @(negedge clk);
    we_c = '0; sb_set_c = 1'b0;
    #1;
    checks++;
    if (rd_c !== 128'h0 || rpend_c !== 4'b0000) begin
      errors++;
      $display("FAIL oor_next_cycle: rd=%h rpend=%b, expected 0/0000", rd_c, rpend_c);
    end
    ra_c = {4{5'd4}};
    #1;
    checks++;
    if (rd_c !== 128'h0 || rpend_c !== 4'b0000) begin
      errors++;
      $display("FAIL oor_no_alias: rd=%h rpend=%b, expected 0/0000", rd_c, rpend_c);
    end
    @(negedge clk);
    we_c = 1'b1; wa_c = 5'd15; wd_c = 32'h0F0F0F0F; ra_c = {4{5'd15}};
    #1;
    checks++;
    if (rd_c !== {4{32'h0F0F0F0F}}) begin
      errors++;
      $display("FAIL x15_bypass_4port: rd=%h, expected 4x0f0f0f0f", rd_c);
    end
    @(negedge clk);
    we_c = '0;
    #1;
    checks++;
    if (rd_c !== {4{32'h0F0F0F0F}} || rpend_c !== 4'b0000) begin
      errors++;
      $display("FAIL x15_stored_4port: rd=%h rpend=%b, expected 4x0f0f0f0f/0000", rd_c, rpend_c);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [4] = '{32'h01020304, 32'hFFFFFFFF, 32'h80000001, 32'h0000BEEF};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      we_a = 2'b01; wa_a = {5'd0, 5'(20 + k)}; wd_a = {32'h0, vals[k]};
    end
    @(negedge clk);
    we_a = '0;
    for (int k = 0; k < 4; k += 2) begin
      ra_a = {5'(21 + k), 5'(20 + k)};
      #1;
      checks++;
      if (rd_a !== {vals[k+1], vals[k]}) begin
        errors++;
        $display("FAIL back_to_back_%0d: rd=%h, expected %h%h", k, rd_a, vals[k+1], vals[k]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_x0_guard();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_corner();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Multi-port, parametrised integer register file for the pipelined RISC-V core. Successor to the single-write, two-read file.
- Adds configurable read/write port counts and an asynchronous reset that clears all state.
- Adds optional same-cycle write-to-read bypass and a per-register pending-write scoreboard, which the hazard unit uses for load-use and multi-cycle stalls.
- Sits between decode (reads, scoreboard set) and writeback (writes, scoreboard clear).

Parameters:
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.
- DEPTH, 32: number of registers, 2 to 2**ADDR_W.
- NR, 2: number of read ports, 1 to 4.
- NW, 1: number of write ports, 1 to 2.
- BYPASS, 1: 1 = a write in the current cycle is visible on the read ports in the same cycle; 0 = writes are visible from the next cycle.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ra  in  NR*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd  out  NR*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W].
- rpend  out  NR  bit i = 1 when register ra[i] has a write pending in the scoreboard.
- we  in  NW  write enables.
- wa  in  NW*ADDR_W  write addresses.
- wd  in  NW*DATA_W  write data.
- sb_set  in  1  marks register sb_addr as pending (issued producer).
- sb_addr  in  ADDR_W  scoreboard set address.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - While rst_n = 0, all DEPTH registers are 0 and all scoreboard bits are 0.
  - Therefore rd = 0 and rpend = 0 for every address during and immediately after reset.
  - Reset asserted mid-operation discards any in-flight write or scoreboard set in that cycle.
- Register 0:
  - Hardwired to zero. Writes to address 0 are ignored.
  - Reads of address 0 return 0 and rpend = 0, regardless of BYPASS or scoreboard inputs.
- Out-of-range addresses (addr >= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - Writes are ignored and sb_set is ignored.
  - Reads return 0 with rpend = 0.
- Write:
  - At the rising edge, for each port j with we[j] = 1 and a valid nonzero wa[j], rf[wa[j]] <= wd[j].
  - Latency: 1 edge. The value is architecturally visible after the edge.
- Write-write collision (NW = 2, both enabled, same address): port 1 wins, i.e. rf = wd[1].
- Read:
  - Fully combinational from ra; there is no read latency.
  - BYPASS = 1: if any enabled write port targets ra[i] (nonzero, valid), rd[i] returns that wd, with port 1 taking precedence as above. Otherwise rd[i] = rf[ra[i]].
  - BYPASS = 0: rd[i] = rf[ra[i]]. The old value is returned in the write cycle.
  - Reads on all NR ports are independent. Identical addresses on multiple ports return identical data.
- Scoreboard (one bit per register, excluding register 0):
  - Set: sb_set = 1 sets pend[sb_addr] at the edge.
  - Clear: any enabled write port to an address clears pend[addr] at the edge.
  - Set and clear to the same address in the same edge: set wins, so the bit stays 1 because a new producer has issued.
  - Set and clear to different addresses: both take effect.
- rpend[i]:
  - BYPASS = 1: rpend[i] = pend[ra[i]] AND NOT (any enabled write to ra[i] this cycle). A completing write resolves the hazard combinationally.
  - BYPASS = 0: rpend[i] = pend[ra[i]].
- No other state. No X may propagate from rf to rd after reset.

Test Plan:
- Reset then read: rst_n = 0 for 2 cycles, release; read x5, x31 on both ports -> rd = 0x00000000, rpend = 0. Assert rst_n = 0 asynchronously mid-cycle after writing x5 = 0x12345678 -> x5 reads 0 immediately.
- x0 guard: we = 1, wa = 0, wd = 0xDEADBEEF, sb_set = 1, sb_addr = 0 -> next cycle ra = 0 gives rd = 0, rpend = 0.
- Bypass: BYPASS = 1, write x7 = 0xCAFEF00D with ra[0] = 7 in the same cycle -> rd[0] = 0xCAFEF00D in that cycle. Repeat with BYPASS = 0 -> old value 0 in that cycle, 0xCAFEF00D in the next.
- Dual-write collision: NW = 2, both ports write x3 (0x11111111 on port 0, 0x22222222 on port 1) -> bypassed read and next-cycle read both give 0x22222222.
- Scoreboard lifecycle: sb_set on x9 -> rpend = 1 on the following cycles. Write x9 = 0xA5A5A5A5 -> rpend = 0 in the same cycle (BYPASS = 1) and after. Then set and write x9 in the same edge -> rpend stays 1.
- Parametrised corner: DEPTH = 16, ADDR_W = 5, NR = 4. Write and sb_set on address 20 -> ignored, read 20 gives 0 with rpend = 0. All four read ports on x15 after writing 0x0F0F0F0F -> all four return 0x0F0F0F0F.
